// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// FSM encodings, lane geometry and strobe levels.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;
    localparam logic [3:0]  SEL_NONE      = 4'b0000;

    function automatic logic [3:0] lane_we(input logic en, input logic [3:0] sel);
        return en ? sel : SEL_NONE;
    endfunction

endpackage

// File: rtl/data_ram_bank.sv
// Byte-lane synchronous single-port RAM, four 8-bit lanes.
// Read data is registered only on a read strobe, so it holds otherwise.
module data_ram_bank
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] rd_word;

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we[g] == WRITE_ENABLE) begin
                mem[addr] <= wdata[g*LANE_W +: LANE_W];
            end
        end

        assign rd_word[g*LANE_W +: LANE_W] = mem[addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= ZERO_WORD;
        end else if (re) begin
            rdata <= rd_word;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: wait states, byte-lane store,
// word load, one-cycle ack and stall request to pipeline control.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        stallreq_o
);

    localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

    state_e                state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [31:0]           data_q;
    logic [ADDR_WIDTH-1:0] idx_q;

    logic [ADDR_WIDTH-1:0] idx_in;
    logic                  in_idle;
    logic                  access;
    logic                  acc_we;
    logic [3:0]            acc_sel;
    logic [31:0]           acc_data;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [3:0]            ram_we;
    logic                  ram_re;
    logic                  unused_addr_bits;

    assign idx_in  = mem_addr_i[ADDR_WIDTH+1:2];
    assign in_idle = (state == ST_IDLE);

    // Zero-wait builds access from live inputs; otherwise from latched copy.
    assign access = rst & (mem_ce_i == CHIP_ENABLE)
                  & ((in_idle & ZERO_WAIT)
                   | ((state == ST_WAIT) & (cnt == 4'd0)));

    assign acc_we   = in_idle ? mem_we_i   : we_q;
    assign acc_sel  = in_idle ? mem_sel_i  : sel_q;
    assign acc_data = in_idle ? mem_data_i : data_q;
    assign acc_idx  = in_idle ? idx_in     : idx_q;

    assign ram_we = lane_we(access & acc_we, acc_sel);
    assign ram_re = access & (acc_we == WRITE_DISABLE);

    assign stallreq_o = mem_ce_i & (state != ST_ACK);

    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_WIDTH+2], mem_addr_i[1:0]};

    data_ram_bank #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (ram_we),
        .re   (ram_re),
        .addr (acc_idx),
        .wdata(acc_data),
        .rdata(mem_data_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            mem_ack_o <= 1'b0;
            we_q      <= WRITE_DISABLE;
            sel_q     <= SEL_NONE;
            data_q    <= ZERO_WORD;
            idx_q     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    mem_ack_o <= 1'b0;
                    if (mem_ce_i == CHIP_ENABLE) begin
                        we_q   <= mem_we_i;
                        sel_q  <= mem_sel_i;
                        data_q <= mem_data_i;
                        idx_q  <= idx_in;
                        if (ZERO_WAIT) begin
                            state     <= ST_ACK;
                            mem_ack_o <= 1'b1;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ce_i == CHIP_DISABLE) begin
                        state     <= ST_IDLE;
                        mem_ack_o <= 1'b0;
                    end else if (cnt == 4'd0) begin
                        state     <= ST_ACK;
                        mem_ack_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state     <= ST_IDLE;
                    mem_ack_o <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_ack_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: one responder with two wait states, one with none.
// Expected responses come from a word-array model of the memory.
module tb_data_mem_responder;

    localparam int AW = 10;
    localparam int W0 = 2;
    localparam int W1 = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce   [2];
    logic        we   [2];
    logic [31:0] addr [2];
    logic [3:0]  sel  [2];
    logic [31:0] din  [2];
    logic [31:0] dout0;
    logic [31:0] dout1;
    logic [1:0]  ack;
    logic [1:0]  stall;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] mdl [2][1024];
    logic [31:0] last_load [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst(rst),
        .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_addr_i(addr[0]),
        .mem_sel_i(sel[0]), .mem_data_i(din[0]),
        .mem_data_o(dout0), .mem_ack_o(ack[0]), .stallreq_o(stall[0])
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst(rst),
        .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_addr_i(addr[1]),
        .mem_sel_i(sel[1]), .mem_data_i(din[1]),
        .mem_data_o(dout1), .mem_ack_o(ack[1]), .stallreq_o(stall[1])
    );

    function automatic int waits(int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic logic [31:0] dout_of(int d);
        return (d == 0) ? dout0 : dout1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, required %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Monitors: every ack pops one expected mem_data_o value.
    always @(negedge clk) begin
        if (ack[0] === 1'b1) begin
            if (q0.size() == 0) begin
                n_total++;
                $display("FAIL spurious_ack0: ack=1 with nothing outstanding, required 0");
            end else begin
                chk("data0", dout0, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (ack[1] === 1'b1) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL spurious_ack1: ack=1 with nothing outstanding, required 0");
            end else begin
                chk("data1", dout1, q1.pop_front());
            end
        end
    end

    task automatic req(int d, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] dt);
        int idx;
        int n;
        logic [31:0] e;
        @(posedge clk); #1;
        ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = dt;
        idx = int'(a[AW+1:2]);
        if (w) begin
            e = mdl[d][idx];
            for (int b = 0; b < 4; b++)
                if (s[b]) e[8*b +: 8] = dt[8*b +: 8];
            mdl[d][idx] = e;
        end else begin
            last_load[d] = mdl[d][idx];
        end
        if (d == 0) q0.push_back(last_load[d]);
        else        q1.push_back(last_load[d]);
        #1 chk("stall_req", {31'd0, stall[d]}, 32'd1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!ack[d]) begin
                chk("stall_wait", {31'd0, stall[d]}, 32'd1);
                addr[d] = $urandom; din[d] = $urandom;
                sel[d] = 4'($urandom); we[d] = 1'($urandom);
            end
        end while (!ack[d] && n < 20);
        chk("latency", n, waits(d) + 1);
        chk("stall_ack", {31'd0, stall[d]}, 32'd0);
        ce[d] = 1'b0;
    endtask

    task automatic abort_store(logic [31:0] a, logic [31:0] dt);
        @(posedge clk); #1;
        ce[0] = 1'b1; we[0] = 1'b1; addr[0] = a; sel[0] = 4'hF; din[0] = dt;
        @(posedge clk); #1;
        ce[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_noack", {31'd0, ack[0]}, 32'd0);
        end
    endtask

    task automatic rand_op(int d);
        logic [31:0] a;
        a = $urandom;
        a[AW+1:2] = 10'($urandom_range(0, 31));
        req(d, 1'($urandom), a, 4'($urandom), $urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            ce[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h0;
            sel[d] = 4'hF; din[d] = 32'hFFFF_FFFF;
            last_load[d] = 32'h0;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_ack0", {31'd0, ack[0]}, 32'd0);
            chk("rst_ack1", {31'd0, ack[1]}, 32'd0);
            chk("rst_dout0", dout0, 32'h0);
            chk("rst_dout1", dout1, 32'h0);
            chk("rst_stall0", {31'd0, stall[0]}, 32'd1);
            chk("rst_stall1", {31'd0, stall[1]}, 32'd1);
        end
        ce[0] = 1'b0; ce[1] = 1'b0;
        #1 chk("rst_stall_off", {30'd0, stall}, 32'd0);
        rst = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++)
                req(d, 1'b1, 32'(i * 4), 4'hF, $urandom);

        req(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        req(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        chk("word_ld", dout0, 32'hDEAD_BEEF);
        req(0, 1'b1, 32'h0000_0010, 4'h1, 32'h0000_00AA);
        req(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        chk("lane0_ld", dout0, 32'hDEAD_BEAA);
        req(0, 1'b1, 32'h0000_0010, 4'h8, 32'h1100_0000);
        req(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        chk("lane3_ld", dout0, 32'h11AD_BEAA);

        req(0, 1'b1, 32'h0000_1004, 4'hF, 32'h1234_5678);
        req(0, 1'b0, 32'h0000_0004, 4'hF, 32'h0);
        chk("alias_ld", dout0, 32'h1234_5678);
        req(0, 1'b0, 32'h0000_0006, 4'h2, 32'h0);
        chk("misalign_ld", dout0, 32'h1234_5678);

        abort_store(32'h0000_0020, 32'hFFFF_FFFF);
        req(0, 1'b0, 32'h0000_0020, 4'hF, 32'h0);

        req(1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        req(1, 1'b1, 32'h0000_0014, 4'hF, 32'hCAFE_F00D);
        req(1, 1'b0, 32'h0000_0014, 4'hF, 32'h0);
        chk("b2b_ld", dout1, 32'hCAFE_F00D);
        req(1, 1'b1, 32'h0000_0014, 4'h0, 32'h0BAD_0BAD);
        req(1, 1'b0, 32'h0000_0014, 4'hF, 32'h0);
        chk("sel0_ld", dout1, 32'hCAFE_F00D);

        @(posedge clk); #1;
        ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; sel[0] = 4'hF; din[0] = 32'h5555_5555;
        @(posedge clk); #1;
        rst = 1'b0;
        ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'hC; sel[1] = 4'hF; din[1] = 32'hFFFF_FFFF;
        #1;
        chk("midrst_ack0", {31'd0, ack[0]}, 32'd0);
        chk("midrst_dout0", dout0, 32'h0);
        chk("midrst_dout1", dout1, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ce[0] = 1'b0; ce[1] = 1'b0;
        rst = 1'b1;
        last_load[0] = 32'h0; last_load[1] = 32'h0;
        req(0, 1'b1, 32'h0000_0030, 4'h3, 32'h0000_1234);
        req(0, 1'b0, 32'h0000_0008, 4'hF, 32'h0);
        req(1, 1'b0, 32'h0000_000C, 4'hF, 32'h0);

        for (int i = 0; i < 150; i++) rand_op(0);
        for (int i = 0; i < 150; i++) rand_op(1);

        repeat (4) @(posedge clk);
        #1;
        chk("drain0", 32'(q0.size()), 32'd0);
        chk("drain1", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
